// File: rtl/load_store_unit.sv
// Data-side memory stage: turns one core load/store into a memory request, aligns
// store data/byte enables, extends load data, and reports misalignment or timeout.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_misaligned,
   output logic        rsp_timeout,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  dbg_state_o
);

   // Handshakes: a core request transfers on the rising edge where req_valid && req_ready;
   // a memory request transfers where mem_valid && mem_ready; mem_rvalid is a one-cycle data strobe.

   typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    funct3_q;
   logic [1:0]    off_q;
   logic          mem_valid_q, mem_write_q;
   logic [31:0]   mem_addr_q, mem_wdata_q;
   logic [3:0]    mem_be_q;
   logic          rsp_valid_q, rsp_mis_q, rsp_to_q;
   logic [31:0]   rsp_rdata_q;

   logic          legal_d;
   logic [3:0]    be_d;
   logic [31:0]   wdata_d, shifted_d, load_data_d;

   always_comb begin
      legal_d = 1'b0;
      case (req_funct3)
         3'b000:  legal_d = 1'b1;
         3'b001:  legal_d = ~req_addr[0];
         3'b010:  legal_d = (req_addr[1:0] == 2'b00);
         3'b100:  legal_d = ~req_write;
         3'b101:  legal_d = ~req_write & ~req_addr[0];
         default: legal_d = 1'b0;
      endcase
   end

   always_comb begin
      be_d    = 4'b1111;
      wdata_d = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            be_d    = 4'b0001 << req_addr[1:0];
            wdata_d = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            be_d    = 4'b0011 << req_addr[1:0];
            wdata_d = {2{req_wdata[15:0]}};
         end
         default: begin
            be_d    = 4'b1111;
            wdata_d = req_wdata;
         end
      endcase
   end

   assign shifted_d = mem_rdata >> {off_q, 3'b000};

   always_comb begin
      load_data_d = shifted_d;
      case (funct3_q)
         3'b000:  load_data_d = {{24{shifted_d[7]}}, shifted_d[7:0]};
         3'b001:  load_data_d = {{16{shifted_d[15]}}, shifted_d[15:0]};
         3'b100:  load_data_d = {24'b0, shifted_d[7:0]};
         3'b101:  load_data_d = {16'b0, shifted_d[15:0]};
         default: load_data_d = shifted_d;
      endcase
   end

   // The counter saturates at LAST so a completion arriving right at the limit
   // still leaves a bounded window for the following read data.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         funct3_q    <= 3'b000;
         off_q       <= 2'b00;
         mem_valid_q <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         mem_be_q    <= 4'b0000;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_mis_q   <= 1'b0;
         rsp_to_q    <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  funct3_q    <= req_funct3;
                  off_q       <= req_addr[1:0];
                  mem_write_q <= req_write;
                  mem_addr_q  <= {req_addr[31:2], 2'b00};
                  mem_wdata_q <= wdata_d;
                  mem_be_q    <= be_d;
                  cnt_q       <= '0;
                  if (legal_d) begin
                     state_q     <= REQ;
                     mem_valid_q <= 1'b1;
                  end else begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= 32'h0;
                     rsp_mis_q   <= 1'b1;
                     rsp_to_q    <= 1'b0;
                  end
               end
            end
            REQ: begin
               if (cnt_q != LAST) cnt_q <= cnt_q + CW'(1);
               if (mem_ready) begin
                  mem_valid_q <= 1'b0;
                  if (mem_write_q) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= 32'h0;
                     rsp_mis_q   <= 1'b0;
                     rsp_to_q    <= 1'b0;
                  end else begin
                     state_q <= WAIT_R;
                  end
               end else if (cnt_q == LAST) begin
                  mem_valid_q <= 1'b0;
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= 32'h0;
                  rsp_mis_q   <= 1'b0;
                  rsp_to_q    <= 1'b1;
               end
            end
            WAIT_R: begin
               if (cnt_q != LAST) cnt_q <= cnt_q + CW'(1);
               if (mem_rvalid) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= load_data_d;
                  rsp_mis_q   <= 1'b0;
                  rsp_to_q    <= 1'b0;
               end else if (cnt_q == LAST) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= 32'h0;
                  rsp_mis_q   <= 1'b0;
                  rsp_to_q    <= 1'b1;
               end
            end
            RESP: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready      = (state_q == IDLE) & reset;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_rdata      = rsp_rdata_q;
   assign rsp_misaligned = rsp_mis_q;
   assign rsp_timeout    = rsp_to_q;
   assign mem_valid      = mem_valid_q;
   assign mem_write      = mem_write_q;
   assign mem_addr       = mem_addr_q;
   assign mem_wdata      = mem_wdata_q;
   assign mem_be         = mem_be_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random accesses checked
// against a byte-lane arithmetic model of the access rules.
module tb_load_store_unit;
   localparam int T = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_misaligned, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        mem_valid, mem_ready, mem_write, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_misaligned(rsp_misaligned), .rsp_timeout(rsp_timeout),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .dbg_state_o(dbg_state)
   );

   // observations from the last access
   int          o_lat, o_mv;
   logic        o_ready, o_prev_rsp, o_mis, o_to, o_mwrite, o_stable;
   logic [31:0] o_rdata, o_maddr, o_mwdata;
   logic [3:0]  o_be;
   // expectations from the reference model
   int          e_lat, e_mv;
   logic        e_mis, e_to;
   logic [31:0] e_rdata, e_maddr, e_mwdata;
   logic [3:0]  e_be;

   // Cycle k (1-based) of the memory phase; memory accepts at kr = d+1, data returns at kr+r+1.
   task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int d, input int r);
      int size, off, kr, kv, tk;
      logic legal;
      logic [31:0] mask, val;
      off  = int'(addr % 4);
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      legal = (int'(addr % size) == 0) &&
              (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || (!wr && (f3 == 3'd4 || f3 == 3'd5)));
      e_maddr = addr & ~32'h3;
      e_be    = 4'((((1 << size) - 1) << off) & 15);
      for (int i = 0; i < 4; i++) e_mwdata[8*i +: 8] = wd[8*(i % size) +: 8];
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*size)) - 32'h1);
      val  = (rd >> (8*off)) & mask;
      if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~mask;
      kr = d + 1;
      e_to = 1'b0; e_rdata = 32'h0;
      if (!legal) begin
         e_mis = 1'b1; e_lat = 1; e_mv = 0;
      end else begin
         e_mis = 1'b0;
         e_mv  = (kr < T) ? kr : T;
         if (kr > T) begin
            e_to = 1'b1; e_lat = T + 1;
         end else if (wr) begin
            e_lat = kr + 1;
         end else begin
            tk = (kr + 1 > T) ? kr + 1 : T;
            kv = kr + r + 1;
            if (kv <= tk) begin
               e_rdata = val; e_lat = kv + 1;
            end else begin
               e_to = 1'b1; e_lat = tk + 1;
            end
         end
      end
   endtask

   // Issues one request and plays the memory: accept after d stall cycles, data r cycles later.
   task automatic run_access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd, input int d, input int r);
      int stall, wcnt;
      logic first, acc_done;
      @(negedge clk);
      o_ready = req_ready; o_prev_rsp = rsp_valid;
      req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
      o_lat = -1; o_mv = 0; o_stable = 1'b1; o_mis = 1'bx; o_to = 1'bx; o_rdata = 32'hx;
      stall = 0; wcnt = 0; first = 1'b1; acc_done = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (rsp_valid) begin
            o_lat = cyc; o_rdata = rsp_rdata; o_mis = rsp_misaligned; o_to = rsp_timeout;
            break;
         end
         mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
         if (mem_valid) begin
            o_mv++;
            if (first) begin
               o_maddr = mem_addr; o_mwdata = mem_wdata; o_be = mem_be; o_mwrite = mem_write;
               first = 1'b0;
            end else if (mem_addr !== o_maddr || mem_wdata !== o_mwdata || mem_be !== o_be ||
                         mem_write !== o_mwrite) begin
               o_stable = 1'b0;
            end
            if (stall == d) begin
               mem_ready = 1'b1; acc_done = 1'b1;
            end else begin
               stall++;
            end
         end else if (acc_done && !wr) begin
            if (wcnt == r) begin
               mem_rvalid = 1'b1; mem_rdata = rd;
            end
            wcnt++;
         end
         @(negedge clk);
      end
      mem_ready = 1'b0; mem_rvalid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
      req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (req_ready !== 1'b0 || mem_valid !== 1'b0 || rsp_valid !== 1'b0 || mem_be !== 4'b0 ||
          rsp_rdata !== 32'h0 || rsp_misaligned !== 1'b0 || rsp_timeout !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: ready=%b mvalid=%b rvalid=%b be=%b rdata=%h mis=%b to=%b, required all 0",
                  req_ready, mem_valid, rsp_valid, mem_be, rsp_rdata, rsp_misaligned, rsp_timeout);
      end
      reset = 1'b1;
      @(negedge clk);
      total++;
      if (req_ready !== 1'b1) begin
         bad++; $display("FAIL reset_release_ready: got %b, required 1", req_ready);
      end
   endtask

   task automatic test_store_byte();
      run_access(1'b1, 3'b000, 32'h0000_0103, 32'h1234_56AB, 32'h0, 0, 0);
      total++;
      if (o_maddr !== 32'h100 || o_be !== 4'b1000 || o_mwdata !== 32'hABAB_ABAB || o_mwrite !== 1'b1) begin
         bad++; $display("FAIL sb_mem: addr=%h be=%b wdata=%h write=%b, required 100 1000 abababab 1",
                         o_maddr, o_be, o_mwdata, o_mwrite);
      end
      total++;
      if (o_lat !== 2 || o_rdata !== 32'h0 || o_mis !== 1'b0 || o_to !== 1'b0) begin
         bad++; $display("FAIL sb_rsp: lat=%0d rdata=%h mis=%b to=%b, required 2 0 0 0",
                         o_lat, o_rdata, o_mis, o_to);
      end
   endtask

   task automatic test_load_extend();
      run_access(1'b0, 3'b000, 32'h202, 32'h0, 32'h0080_0000, 0, 0);
      total++;
      if (o_rdata !== 32'hFFFF_FF80 || o_lat !== 3) begin
         bad++; $display("FAIL lb: rdata=%h lat=%0d, required ffffff80 3", o_rdata, o_lat);
      end
      run_access(1'b0, 3'b100, 32'h202, 32'h0, 32'h0080_0000, 0, 0);
      total++;
      if (o_rdata !== 32'h0000_0080) begin
         bad++; $display("FAIL lbu: rdata=%h, required 00000080", o_rdata);
      end
      run_access(1'b0, 3'b001, 32'h202, 32'h0, 32'h8001_0000, 0, 0);
      total++;
      if (o_rdata !== 32'hFFFF_8001) begin
         bad++; $display("FAIL lh: rdata=%h, required ffff8001", o_rdata);
      end
   endtask

   task automatic test_misaligned();
      logic [2:0]  f3s [3] = '{3'b010, 3'b001, 3'b011};
      logic [31:0] ads [3] = '{32'h301, 32'h101, 32'h400};
      logic        wrs [3] = '{1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         run_access(wrs[i], f3s[i], ads[i], 32'hDEAD_BEEF, 32'h0, 0, 0);
         total++;
         if (o_lat !== 1 || o_mis !== 1'b1 || o_mv !== 0 || o_to !== 1'b0 || o_rdata !== 32'h0) begin
            bad++; $display("FAIL misaligned_%0d: lat=%0d mis=%b mv=%0d to=%b rdata=%h, required 1 1 0 0 0",
                            i, o_lat, o_mis, o_mv, o_to, o_rdata);
         end
      end
   endtask

   task automatic test_timeout();
      run_access(1'b0, 3'b010, 32'h40, 32'h0, 32'h5555_AAAA, 100, 0);
      total++;
      if (o_mv !== T || o_to !== 1'b1 || o_rdata !== 32'h0 || o_lat !== T + 1) begin
         bad++; $display("FAIL timeout: mv=%0d to=%b rdata=%h lat=%0d, required %0d 1 0 %0d",
                         o_mv, o_to, o_rdata, o_lat, T, T + 1);
      end
      run_access(1'b0, 3'b010, 32'h40, 32'h0, 32'h5555_AAAA, T - 1, 0);
      total++;
      if (o_to !== 1'b0 || o_rdata !== 32'h5555_AAAA || o_lat !== T + 2) begin
         bad++; $display("FAIL timeout_edge: to=%b rdata=%h lat=%0d, required 0 5555aaaa %0d",
                         o_to, o_rdata, o_lat, T + 2);
      end
   endtask

   task automatic test_reset_mid_access();
      logic seen;
      // reset while the memory request is pending
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80;
      @(negedge clk);
      req_valid = 1'b0;
      total++;
      if (mem_valid !== 1'b1) begin
         bad++; $display("FAIL rst_req_pre: mem_valid=%b, required 1", mem_valid);
      end
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (mem_valid !== 1'b0 || req_ready !== 1'b0) begin
         bad++; $display("FAIL rst_req_drop: mem_valid=%b ready=%b, required 0 0", mem_valid, req_ready);
      end
      reset = 1'b1;
      // reset while waiting for read data, then a stale rvalid
      @(negedge clk);
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0; reset = 1'b0;
      @(negedge clk);
      reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      @(negedge clk);
      mem_rvalid = 1'b0;
      total++;
      if (req_ready !== 1'b1) begin
         bad++; $display("FAIL rst_wait_ready: got %b, required 1", req_ready);
      end
      seen = 1'b0;
      repeat (4) begin
         if (rsp_valid !== 1'b0) seen = 1'b1;
         @(negedge clk);
      end
      total++;
      if (seen !== 1'b0) begin
         bad++; $display("FAIL rst_no_rsp: rsp_valid seen=%b, required 0", seen);
      end
   endtask

   task automatic test_stall_back_to_back();
      run_access(1'b1, 3'b001, 32'h0000_0A02, 32'hCAFE_1234, 32'h0, 3, 0);
      total++;
      if (o_stable !== 1'b1 || o_mv !== 4 || o_be !== 4'b1100 || o_mwdata !== 32'h1234_1234 || o_lat !== 5) begin
         bad++; $display("FAIL stall: stable=%b mv=%0d be=%b wdata=%h lat=%0d, required 1 4 1100 12341234 5",
                         o_stable, o_mv, o_be, o_mwdata, o_lat);
      end
      for (int i = 0; i < 3; i++) begin
         run_access(1'b0, 3'b010, 32'h100 + 32'(4*i), 32'h0, 32'h0 + 32'(i), 0, 0);
         total++;
         if (o_ready !== 1'b1 || o_prev_rsp !== 1'b0 || o_lat !== 3 || o_rdata !== 32'(i)) begin
            bad++; $display("FAIL b2b_%0d: ready=%b prev_rsp=%b lat=%0d rdata=%h, required 1 0 3 %h",
                            i, o_ready, o_prev_rsp, o_lat, o_rdata, 32'(i));
         end
      end
   endtask

   task automatic test_random();
      logic wr;
      logic [2:0] f3;
      logic [31:0] addr, wd, rd;
      int d, r;
      for (int n = 0; n < 60; n++) begin
         wr = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
         addr = $urandom; wd = $urandom; rd = $urandom;
         d = $urandom_range(0, 4); r = $urandom_range(0, 2);
         model(wr, f3, addr, wd, rd, d, r);
         run_access(wr, f3, addr, wd, rd, d, r);
         total++;
         if (o_lat !== e_lat || o_mis !== e_mis || o_to !== e_to || o_rdata !== e_rdata || o_mv !== e_mv) begin
            bad++; $display("FAIL rand_rsp_%0d: lat=%0d mis=%b to=%b rdata=%h mv=%0d, required %0d %b %b %h %0d (wr=%b f3=%0d addr=%h d=%0d r=%0d)",
                            n, o_lat, o_mis, o_to, o_rdata, o_mv, e_lat, e_mis, e_to, e_rdata, e_mv, wr, f3, addr, d, r);
         end
         if (!e_mis) begin
            total++;
            if (o_maddr !== e_maddr || o_stable !== 1'b1 || o_mwrite !== wr ||
                (wr && (o_be !== e_be || o_mwdata !== e_mwdata))) begin
               bad++; $display("FAIL rand_mem_%0d: addr=%h be=%b wdata=%h write=%b stable=%b, required %h %b %h %b 1",
                               n, o_maddr, o_be, o_mwdata, o_mwrite, o_stable, e_maddr, e_be, e_mwdata, wr);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_store_byte();
      test_load_extend();
      test_misaligned();
      test_timeout();
      test_reset_mid_access();
      test_stall_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
